// File: rtl/ht_init_ctrl_if.sv
// Command/result handshake bundle around the hash pipeline entry gate.
// slave = gate controller view, master = upstream/pipeline side.
interface ht_init_ctrl_if;
  logic cmd_valid_i;
  logic cmd_ready_o;
  logic cmd_valid_o;
  logic cmd_ready_i;
  logic res_valid_i;
  logic res_ready_i;

  modport slave (
    input  cmd_valid_i, cmd_ready_i, res_valid_i, res_ready_i,
    output cmd_valid_o, cmd_ready_o
  );

  modport master (
    output cmd_valid_i, cmd_ready_i, res_valid_i, res_ready_i,
    input  cmd_valid_o, cmd_ready_o
  );
endinterface

// File: rtl/ht_init_ctrl.sv
// Hash-table init/re-init sequencer: clears head/data tables, then gates commands and tracks outstanding.
// Gate is combinational (0 cycles) and only open in RUN below a full counter; otherwise valid/ready forced low.
module ht_init_ctrl #(
  parameter int CLR_TIMEOUT = 1024,
  parameter int OUTST_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ht_init_ctrl_if.slave      cmd_if,
  output logic               head_clear_run_o,
  input  logic               head_clear_done_i,
  output logic               data_clear_run_o,
  input  logic               data_clear_done_i,
  input  logic               reinit_req_i,
  output logic               init_done_o,
  output logic               error_o,
  output logic [OUTST_W-1:0] outstanding_o,
  output logic [2:0]         state_o
);

  localparam logic [2:0] ST_INIT        = 3'd0;
  localparam logic [2:0] ST_CLEAR_START = 3'd1;
  localparam logic [2:0] ST_CLEAR_WAIT  = 3'd2;
  localparam logic [2:0] ST_RUN         = 3'd3;
  localparam logic [2:0] ST_DRAIN       = 3'd4;
  localparam logic [2:0] ST_ERROR       = 3'd5;

  localparam int              TMO_W    = $clog2(CLR_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CLR_TIMEOUT - 1);

  logic [2:0]         state_q, state_d;
  logic               head_flag_q, head_flag_d;
  logic               data_flag_q, data_flag_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic               gate_open;
  logic               cmd_acc;
  logic               res_ret;

  // Full counter closes the gate so the count can never wrap.
  assign gate_open          = (state_q == ST_RUN) && !(&outst_q);
  assign cmd_if.cmd_valid_o = gate_open & cmd_if.cmd_valid_i;
  assign cmd_if.cmd_ready_o = gate_open & cmd_if.cmd_ready_i;

  assign cmd_acc = cmd_if.cmd_valid_o & cmd_if.cmd_ready_i;
  assign res_ret = cmd_if.res_valid_i & cmd_if.res_ready_i;

  always_comb begin
    outst_d = outst_q;
    if (cmd_acc && !res_ret) begin
      outst_d = outst_q + OUTST_W'(1);
    end else if (res_ret && !cmd_acc && (outst_q != '0)) begin
      outst_d = outst_q - OUTST_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    head_flag_d = head_flag_q;
    data_flag_d = data_flag_q;
    tmo_d       = tmo_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_CLEAR_START;
      end
      ST_CLEAR_START: begin
        head_flag_d = 1'b0;
        data_flag_d = 1'b0;
        tmo_d       = '0;
        state_d     = ST_CLEAR_WAIT;
      end
      ST_CLEAR_WAIT: begin
        // Completion is checked before timeout so a last-cycle done still wins.
        head_flag_d = head_flag_q | head_clear_done_i;
        data_flag_d = data_flag_q | data_clear_done_i;
        if (head_flag_d && data_flag_d) begin
          state_d = ST_RUN;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RUN: begin
        if (reinit_req_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outst_q == '0) begin
          state_d = ST_CLEAR_START;
        end
      end
      ST_ERROR: begin
        if (reinit_req_i) begin
          state_d = ST_CLEAR_START;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_INIT;
      head_flag_q <= 1'b0;
      data_flag_q <= 1'b0;
      tmo_q       <= '0;
      outst_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_flag_q <= head_flag_d;
      data_flag_q <= data_flag_d;
      tmo_q       <= tmo_d;
      outst_q     <= outst_d;
    end
  end

  assign head_clear_run_o = (state_q == ST_CLEAR_START);
  assign data_clear_run_o = (state_q == ST_CLEAR_START);
  assign init_done_o      = (state_q == ST_RUN);
  assign error_o          = (state_q == ST_ERROR);
  assign outstanding_o    = outst_q;
  assign state_o          = state_q;

endmodule
